tanh_share_arbiter: RTL and testbench

//  Shares one pipelined tanh unit (Q8.8, fixed latency, no valid/handshake of its own)

---
 rtl/tanh_share_arbiter.sv | 134 +++++++++++++
 tb/tb_tanh_share_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/tanh_share_arbiter.sv
// Round-robin share of one fixed-latency tanh unit among NUM_REQ requesters.
// A tag/valid shadow pipe steers each result back; a drain FSM quiesces the unit.
module tanh_share_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int DATA_W       = 16,
   parameter int TANH_LATENCY = 5
) (
   input  logic                                 clock,
   input  logic                                 reset,
   input  logic [NUM_REQ-1:0]                   req_valid,
   input  logic [NUM_REQ*DATA_W-1:0]            req_data,
   output logic [NUM_REQ-1:0]                   req_ready,
   output logic [DATA_W-1:0]                    tanh_in_data,
   input  logic [DATA_W-1:0]                    tanh_out_data,
   output logic [NUM_REQ-1:0]                   resp_valid,
   output logic [DATA_W-1:0]                    resp_data,
   input  logic                                 drain_req,
   output logic                                 drain_done,
   output logic [$clog2(TANH_LATENCY+1)-1:0]    inflight
);

   localparam int TAG_W = $clog2(NUM_REQ);
   localparam int INF_W = $clog2(TANH_LATENCY+1);

   typedef enum logic [1:0] {RUN, DRAIN, DRAINED} state_t;

   state_t                    state_q, state_d;
   logic [TAG_W-1:0]          rr_ptr_q, rr_ptr_d;
   logic [TANH_LATENCY-1:0]   shadow_vld_q, shadow_vld_d;
   logic [TAG_W-1:0]          shadow_tag_q [TANH_LATENCY];
   logic [TAG_W-1:0]          shadow_tag_d [TANH_LATENCY];
   logic [NUM_REQ-1:0]        resp_valid_q, resp_valid_d;
   logic [DATA_W-1:0]         resp_data_q, resp_data_d;
   logic [INF_W-1:0]          inflight_q, inflight_d;

   logic                      grant_found;
   logic [TAG_W-1:0]          grant_idx;
   logic [TAG_W-1:0]          cand;
   logic                      accept;
   logic                      tail_vld;
   logic [TAG_W-1:0]          tail_tag;

   function automatic logic [TAG_W-1:0] wrap_inc(input logic [TAG_W-1:0] v);
      if (v == TAG_W'(NUM_REQ-1)) return '0;
      return v + TAG_W'(1);
   endfunction

   assign tail_vld = shadow_vld_q[TANH_LATENCY-1];
   assign tail_tag = shadow_tag_q[TANH_LATENCY-1];

   // Arbitration: first valid requester at or after rr_ptr, wrapping.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = rr_ptr_q;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!grant_found && req_valid[cand]) begin
            grant_found = 1'b1;
            grant_idx   = cand;
         end
         cand = wrap_inc(cand);
      end
      accept       = (state_q == RUN) && !drain_req && grant_found;
      req_ready    = '0;
      tanh_in_data = '0;
      if (accept) begin
         req_ready[grant_idx] = 1'b1;
         tanh_in_data         = req_data[int'(grant_idx)*DATA_W +: DATA_W];
      end
   end

   // Shadow pipe, response capture, occupancy and pointer update.
   always_comb begin
      shadow_vld_d[0] = accept;
      shadow_tag_d[0] = grant_idx;
      for (int i = 1; i < TANH_LATENCY; i++) begin
         shadow_vld_d[i] = shadow_vld_q[i-1];
         shadow_tag_d[i] = shadow_tag_q[i-1];
      end

      resp_valid_d = '0;
      resp_data_d  = resp_data_q;
      if (tail_vld) begin
         resp_valid_d[tail_tag] = 1'b1;
         resp_data_d            = tanh_out_data;
      end

      inflight_d = inflight_q;
      if (accept && !tail_vld)      inflight_d = inflight_q + INF_W'(1);
      else if (!accept && tail_vld) inflight_d = inflight_q - INF_W'(1);

      rr_ptr_d = accept ? wrap_inc(grant_idx) : rr_ptr_q;
   end

   // A lowered drain_req takes priority over reaching empty.
   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN:     if (drain_req) state_d = DRAIN;
         DRAIN: begin
            if (!drain_req)                           state_d = RUN;
            else if (inflight_q == '0 && !tail_vld)   state_d = DRAINED;
         end
         DRAINED: if (!drain_req) state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= RUN;
         rr_ptr_q     <= '0;
         shadow_vld_q <= '0;
         for (int i = 0; i < TANH_LATENCY; i++) shadow_tag_q[i] <= '0;
         resp_valid_q <= '0;
         resp_data_q  <= '0;
         inflight_q   <= '0;
      end else begin
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         shadow_vld_q <= shadow_vld_d;
         for (int i = 0; i < TANH_LATENCY; i++) shadow_tag_q[i] <= shadow_tag_d[i];
         resp_valid_q <= resp_valid_d;
         resp_data_q  <= resp_data_d;
         inflight_q   <= inflight_d;
      end
   end

   assign resp_valid = resp_valid_q;
   assign resp_data  = resp_data_q;
   assign inflight   = inflight_q;
   assign drain_done = (state_q == DRAINED);

endmodule

// File: tb/tb_tanh_share_arbiter.sv
// Randomized and directed bench for tanh_share_arbiter against a queue-based reference
// model; the tanh unit is a stub returning in + 1 after TANH_LATENCY cycles.
module tb_tanh_share_arbiter;

   localparam int NR = 4;
   localparam int DW = 16;
   localparam int L  = 5;
   localparam int IW = $clog2(L+1);

   logic               clock = 1'b0;
   logic               reset;
   logic [NR-1:0]      req_valid;
   logic [NR*DW-1:0]   req_data;
   logic [NR-1:0]      req_ready;
   logic [DW-1:0]      tanh_in_data;
   logic [DW-1:0]      tanh_out_data;
   logic [NR-1:0]      resp_valid;
   logic [DW-1:0]      resp_data;
   logic               drain_req;
   logic               drain_done;
   logic [IW-1:0]      inflight;

   tanh_share_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .TANH_LATENCY(L)) dut (
      .clock(clock), .reset(reset), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .tanh_in_data(tanh_in_data), .tanh_out_data(tanh_out_data),
      .resp_valid(resp_valid), .resp_data(resp_data), .drain_req(drain_req),
      .drain_done(drain_done), .inflight(inflight)
   );

   always #5 clock = ~clock;

   // tanh stub: operand captured mid-cycle, returned + 1 exactly L cycles later
   logic [DW-1:0] stub_in;
   logic [DW-1:0] stub_pipe [L];
   always @(negedge clock) stub_in <= tanh_in_data;
   always @(posedge clock) begin
      stub_pipe[0] <= stub_in;
      for (int i = 1; i < L; i++) stub_pipe[i] <= stub_pipe[i-1];
   end
   assign tanh_out_data = stub_pipe[L-1] + 16'h0001;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
      end
   endtask

   // Reference model: pending operations in issue order, stamped with issue cycle.
   typedef struct {
      int            cyc;
      int            tag;
      logic [DW-1:0] data;
   } op_t;
   op_t           q[$];
   int            m_rr;
   int            m_mode;   // 0 run, 1 draining, 2 drained
   logic [NR-1:0] m_rv;
   logic [DW-1:0] m_rd;
   int            cyc;

   logic [NR-1:0] last_ready;
   logic [NR-1:0] last_rv;
   logic [DW-1:0] last_rd;
   logic          last_dd;

   task automatic model_reset();
      q.delete();
      m_rr = 0; m_mode = 0; m_rv = '0; m_rd = '0; cyc = 0;
   endtask

   // Called at posedge+1: drive one cycle, check at negedge, advance model, reach next posedge+1.
   task automatic step(input logic [NR-1:0] v, input logic [NR*DW-1:0] d, input logic dr);
      logic [NR-1:0] e_ready;
      logic [DW-1:0] e_in;
      int            g;
      bit            was_empty;
      op_t           op;
      req_valid = v; req_data = d; drain_req = dr;
      @(negedge clock);
      e_ready = '0; e_in = '0; g = -1;
      if (m_mode == 0 && !dr) begin
         for (int k = 0; k < NR; k++) begin
            if (g < 0 && v[(m_rr + k) % NR]) g = (m_rr + k) % NR;
         end
      end
      if (g >= 0) begin
         e_ready[g] = 1'b1;
         e_in       = d[g*DW +: DW];
      end
      chk("req_ready",    req_ready,    e_ready);
      chk("tanh_in_data", tanh_in_data, e_in);
      chk("resp_valid",   resp_valid,   m_rv);
      chk("resp_data",    resp_data,    m_rd);
      chk("inflight",     inflight,     q.size());
      chk("drain_done",   drain_done,   m_mode == 2);
      last_ready = req_ready; last_rv = resp_valid; last_rd = resp_data; last_dd = drain_done;

      was_empty = (q.size() == 0);
      if (q.size() > 0 && q[0].cyc + L == cyc) begin
         m_rv = '0;
         m_rv[q[0].tag] = 1'b1;
         m_rd = q[0].data + 16'h0001;
         void'(q.pop_front());
      end else begin
         m_rv = '0;
      end
      if (g >= 0) begin
         op.cyc = cyc; op.tag = g; op.data = e_in;
         q.push_back(op);
         m_rr = (g + 1) % NR;
      end
      case (m_mode)
         0: if (dr) m_mode = 1;
         1: if (!dr) m_mode = 0; else if (was_empty) m_mode = 2;
         default: if (!dr) m_mode = 0;
      endcase
      cyc++;
      @(posedge clock);
      #1;
   endtask

   function automatic logic [NR*DW-1:0] rand_data();
      logic [NR*DW-1:0] r;
      for (int i = 0; i < NR; i++) r[i*DW +: DW] = DW'($urandom);
      return r;
   endfunction

   logic rdr;

   initial begin
      reset = 1'b1; req_valid = '0; req_data = '0; drain_req = 1'b0;
      model_reset();
      #1;
      chk("rst_resp_valid", resp_valid, 4'b0000);
      chk("rst_resp_data",  resp_data,  16'h0000);
      chk("rst_inflight",   inflight,   0);
      chk("rst_drain_done", drain_done, 1'b0);
      @(posedge clock); @(posedge clock); #1;
      reset = 1'b0;

      // single request
      step(4'b0001, 64'h0000_0000_0000_0100, 1'b0);
      chk("t1_grant", last_ready, 4'b0001);
      for (int i = 1; i <= 8; i++) begin
         step('0, '0, 1'b0);
         if (i == 6) begin
            chk("t1_resp_valid", last_rv, 4'b0001);
            chk("t1_resp_data",  last_rd, 16'h0101);
         end
      end

      // all requesters every cycle, then drain the tail
      for (int i = 0; i < 12; i++) step(4'b1111, rand_data(), 1'b0);
      for (int i = 0; i < 8; i++)  step('0, '0, 1'b0);

      // wrap and skip
      step(4'b0100, rand_data(), 1'b0);
      step(4'b0010, rand_data(), 1'b0);
      chk("t3_skip_grant", last_ready, 4'b0010);
      step(4'b1111, rand_data(), 1'b0);
      chk("t3_ptr_after", last_ready, 4'b0100);
      for (int i = 0; i < 8; i++) step('0, '0, 1'b0);

      // drain with three in flight
      for (int i = 0; i < 3; i++) step(4'b1000, rand_data(), 1'b0);
      step(4'b1111, rand_data(), 1'b1);
      chk("t4_ready_blocked", last_ready, 4'b0000);
      for (int i = 0; i < 10; i++) step(4'b1111, rand_data(), 1'b1);
      chk("t4_drained", last_dd, 1'b1);
      step(4'b1111, rand_data(), 1'b0);
      chk("t4_no_issue_on_exit", last_ready, 4'b0000);
      for (int i = 0; i < 3; i++) step(4'b1111, rand_data(), 1'b0);
      for (int i = 0; i < 8; i++) step('0, '0, 1'b0);

      // randomized traffic with occasional drain episodes
      rdr = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 19) == 0) rdr = ~rdr;
         step(NR'($urandom), rand_data(), rdr);
      end
      for (int i = 0; i < 10; i++) step('0, '0, 1'b0);

      // reset with operations in flight and a response on the output
      for (int i = 0; i < 8; i++) step(4'b1111, rand_data(), 1'b0);
      #2;
      reset = 1'b1;
      #1;
      chk("t5_resp_valid_async", resp_valid, 4'b0000);
      chk("t5_inflight_async",   inflight,   0);
      chk("t5_resp_data_async",  resp_data,  16'h0000);
      @(posedge clock); #1;
      model_reset();
      step('0, '0, 1'b0);
      reset = 1'b0;
      for (int i = 0; i < 10; i++) step('0, '0, 1'b0);

      // idle: pointer must hold, nothing issued or returned
      step(4'b0100, rand_data(), 1'b0);
      for (int i = 0; i < 20; i++) step('0, rand_data(), 1'b0);
      step(4'b1111, rand_data(), 1'b0);
      chk("t6_ptr_held", last_ready, 4'b1000);
      for (int i = 0; i < 8; i++) step('0, '0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
